// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Prefetching fetch stage for the single-cycle core. Issues in-order word
// fetches to a variable-latency instruction memory, tags each request with its
// PC in a small in-order queue, buffers returned words in a FIFO and hands
// {instr, pc, pc+4} to the core. A redirect from the core flushes the FIFO and
// discards every response still in flight at that moment.
//
// Configuration macro: IFU_BYPASS_EN
//   defined   : a response that arrives while the FIFO is empty, nothing is
//               being dropped and no redirect is active is driven straight onto
//               the instr outputs in its arrival cycle (latency 0); if the core
//               takes it in that cycle it is never written to the FIFO.
//   undefined : every response goes through the FIFO; core-side outputs come
//               from registers only (latency 1).
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous, active-low reset
//   redirect_valid   in   core takes a branch/jump this cycle
//   redirect_pc      in   new fetch PC (bits [1:0] ignored)
//   imem_req_valid   out  fetch request valid
//   imem_req_ready   in   memory accepts request
//   imem_req_addr    out  word-aligned fetch address
//   imem_resp_valid  in   response valid (request order, no backpressure)
//   imem_resp_data   in   fetched instruction word
//   instr_valid      out  instruction available to the core
//   instr_ready      in   core consumes the instruction
//   instr            out  instruction word
//   instr_pc         out  PC of instr
//   instr_pcplus4    out  instr_pc + 4 (mod 2^32)
//   o_dbg_state      out  current FSM state (IDLE=0, RUN=1, FLUSH=2)
//
// Handshakes: a transfer happens on a rising edge where valid && ready. Once
// imem_req_valid is raised it stays high with a stable address until accepted;
// the only exception is a redirect, which retargets the fetch PC. instr_valid
// is held with stable contents until instr_ready, except across a redirect.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pcplus4,
   output logic [1:0]  o_dbg_state
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   localparam logic [31:0] MAX_OUT_U = 32'(MAX_OUTSTANDING);
   localparam logic [31:0] DEPTH_U   = 32'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [31:0]   r_fetch_pc;
   logic [OW-1:0] r_outstanding;
   logic [OW-1:0] r_drop_cnt;

   logic [31:0]   r_fifo_instr [FIFO_DEPTH];
   logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   // PCs of issued requests, oldest first; responses come back in the same order
   logic [31:0]   r_tag_q [MAX_OUTSTANDING];
   logic [TW-1:0] r_tag_wr;
   logic [TW-1:0] r_tag_rd;

   logic          w_req_valid;
   logic          w_req_hs;
   logic          w_resp_acc;
   logic          w_resp_keep;
   logic [31:0]   w_resp_pc;
   logic          w_fifo_empty;
   logic          w_bypass;
   logic          w_push;
   logic          w_pop;
   logic [OW-1:0] w_out_next;
   logic [OW-1:0] w_drop_next;
   logic [31:0]   w_fetch_pc_next;
   logic [31:0]   w_head_pc;
   logic          w_unused;

   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
   endfunction

   // A request also reserves a FIFO slot: in-flight plus buffered words never
   // exceed FIFO_DEPTH, so a response always finds room and never overflows.
   assign w_req_valid = (r_state != ST_IDLE)
                      && (32'(r_outstanding) < MAX_OUT_U)
                      && ((32'(r_outstanding) + 32'(r_count)) < DEPTH_U);
   assign w_req_hs    = w_req_valid && imem_req_ready;

   // A response with nothing outstanding is spurious and ignored entirely.
   assign w_resp_acc  = imem_resp_valid && (r_outstanding != '0);
   // Responses still counted in drop_cnt, or arriving with a redirect, are stale.
   assign w_resp_keep = w_resp_acc && (r_drop_cnt == '0) && !redirect_valid;
   assign w_resp_pc   = r_tag_q[r_tag_rd];

   assign w_fifo_empty = (r_count == '0);

`ifdef IFU_BYPASS_EN
   assign w_bypass = w_resp_keep && w_fifo_empty;
   assign w_push   = w_resp_keep && !(w_bypass && instr_ready);
`else
   assign w_bypass = 1'b0;
   assign w_push   = w_resp_keep;
`endif

   // Redirect wins over the core's consume: the whole FIFO is thrown away.
   assign w_pop = !w_fifo_empty && instr_ready && !redirect_valid;

   assign w_out_next = r_outstanding + OW'(w_req_hs) - OW'(w_resp_acc);

   // On redirect every request still in flight after this cycle (including a
   // handshake made this very cycle) belongs to the old path.
   assign w_drop_next = redirect_valid ? w_out_next :
                        (w_resp_acc && (r_drop_cnt != '0)) ? (r_drop_cnt - OW'(1)) :
                        r_drop_cnt;

   assign w_fetch_pc_next = redirect_valid ? {redirect_pc[31:2], 2'b00} :
                            w_req_hs       ? (r_fetch_pc + 32'd4) :
                            r_fetch_pc;

   assign w_unused = ^redirect_pc[1:0];

   // --------------------------------------------------------------------------
   // FSM next state
   // --------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            w_state_next = ST_RUN;
         end
         ST_RUN: begin
            if (redirect_valid && (w_out_next != '0)) begin
               w_state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (redirect_valid) begin
               w_state_next = ST_FLUSH;
            end else if (w_drop_next == '0) begin
               w_state_next = ST_RUN;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Control state
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_fetch_pc    <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_tag_wr      <= '0;
         r_tag_rd      <= '0;
      end else begin
         r_state       <= w_state_next;
         r_fetch_pc    <= w_fetch_pc_next;
         r_outstanding <= w_out_next;
         r_drop_cnt    <= w_drop_next;
         if (redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
         // The tag queue tracks every issued request, stale or not, so it
         // stays aligned with the response stream across redirects.
         if (w_req_hs) begin
            r_tag_wr <= tag_inc(r_tag_wr);
         end
         if (w_resp_acc) begin
            r_tag_rd <= tag_inc(r_tag_rd);
         end
      end
   end

   // --------------------------------------------------------------------------
   // Storage (no reset needed: contents are only read behind count/tag state)
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_instr[r_wr_ptr] <= imem_resp_data;
         r_fifo_pc[r_wr_ptr]    <= w_resp_pc;
      end
      if (w_req_hs) begin
         r_tag_q[r_tag_wr] <= r_fetch_pc;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_fetch_pc;
   assign o_dbg_state    = r_state;

   assign w_head_pc = w_bypass ? w_resp_pc : (w_fifo_empty ? 32'd0 : r_fifo_pc[r_rd_ptr]);

   // Outputs read as zero whenever nothing is valid, matching the reset values.
   assign instr_valid   = w_bypass || !w_fifo_empty;
   assign instr         = w_bypass ? imem_resp_data :
                          (w_fifo_empty ? 32'd0 : r_fifo_instr[r_rd_ptr]);
   assign instr_pc      = w_head_pc;
   assign instr_pcplus4 = instr_valid ? (w_head_pc + 32'd4) : 32'd0;

endmodule
